// File: rtl/tow_match_ctrl_if.sv
// ============================================================================
// Module  : tow_match_ctrl_if
// Brief   : Request/handshake and display bundle for the tug-of-war controller.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface tow_match_ctrl_if #(
    parameter int SCORE_W = 2
);
    logic               slowen;
    // "rand" is a reserved word, so the real-round request is rand_start
    logic               rand_start;
    logic               rand_fake;
    logic               rand_speed;
    logic               winrnd;
    logic               win_player;
    logic               winspeed;
    logic               speed_exit;
    logic               new_match;
    logic               leds_on;
    logic               clear;
    logic [2:0]         led_control;
    logic               fake;
    logic               speed_round;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               match_over;
    logic               match_winner;

    modport master (
        input  slowen, rand_start, rand_fake, rand_speed, winrnd, win_player,
               winspeed, speed_exit, new_match,
        output leds_on, clear, led_control, fake, speed_round, score_a, score_b,
               match_over, match_winner
    );

    modport slave (
        output slowen, rand_start, rand_fake, rand_speed, winrnd, win_player,
               winspeed, speed_exit, new_match,
        input  leds_on, clear, led_control, fake, speed_round, score_a, score_b,
               match_over, match_winner
    );
endinterface

`default_nettype wire

// File: rtl/tow_match_ctrl.sv
// ============================================================================
// Module  : tow_match_ctrl
// Brief   : Tug-of-war round sequencer with best-of-N match scoring.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tow_match_ctrl #(
    parameter int WAIT_TICKS    = 2,
    parameter int REARM_TICKS   = 1,
    parameter int GLOAT_TICKS   = 2,
    parameter int FAKE_TICKS    = 3,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int CNT_W         = 4,
    parameter int SCORE_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    tow_match_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_WAIT       = 4'd1,
        ST_DARK       = 4'd2,
        ST_PLAY       = 4'd3,
        ST_FAKE       = 4'd4,
        ST_SPEED      = 4'd5,
        ST_SPEED_DISP = 4'd6,
        ST_GLOAT      = 4'd7,
        ST_MATCH_END  = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0]   c_wait_last  = CNT_W'(WAIT_TICKS - 1);
    localparam logic [CNT_W-1:0]   c_rearm_last = CNT_W'(REARM_TICKS - 1);
    localparam logic [CNT_W-1:0]   c_gloat_last = CNT_W'(GLOAT_TICKS - 1);
    localparam logic [CNT_W-1:0]   c_fake_last  = CNT_W'(FAKE_TICKS - 1);
    localparam logic [SCORE_W-1:0] c_win_score  = SCORE_W'(ROUNDS_TO_WIN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rearm_q, rearm_d;
    logic               winner_q, winner_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               match_winner_q, match_winner_d;

    logic               w_credit;
    logic               w_credit_player;
    logic [CNT_W-1:0]   w_wait_last;

    assign w_wait_last = rearm_q ? c_rearm_last : c_wait_last;

    always_comb begin
        state_d         = state_q;
        rearm_d         = rearm_q;
        winner_d        = winner_q;
        score_a_d       = score_a_q;
        score_b_d       = score_b_q;
        match_winner_d  = match_winner_q;
        w_credit        = 1'b0;
        w_credit_player = winner_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT;
                rearm_d = 1'b0;
            end
            ST_WAIT: begin
                if (bus.slowen && cnt_q == w_wait_last) state_d = ST_DARK;
            end
            ST_DARK: begin
                if (bus.slowen && bus.rand_fake && !bus.rand_start) begin
                    state_d = ST_FAKE;
                end else if (bus.slowen && bus.rand_speed && !bus.rand_start && !bus.rand_fake) begin
                    state_d = ST_SPEED;
                end else if (bus.slowen && bus.rand_start) begin
                    state_d = ST_PLAY;
                end else if (bus.winrnd) begin
                    // false start: the press still ends the round
                    state_d         = ST_GLOAT;
                    winner_d        = bus.win_player;
                    w_credit        = 1'b1;
                    w_credit_player = bus.win_player;
                end
            end
            ST_PLAY: begin
                if (bus.winrnd) begin
                    state_d         = ST_GLOAT;
                    winner_d        = bus.win_player;
                    w_credit        = 1'b1;
                    w_credit_player = bus.win_player;
                end
            end
            ST_FAKE: begin
                if (bus.slowen && cnt_q == c_fake_last) begin
                    if (bus.winrnd) begin
                        state_d         = ST_GLOAT;
                        winner_d        = bus.win_player;
                        w_credit        = 1'b1;
                        w_credit_player = bus.win_player;
                    end else begin
                        state_d = ST_DARK;
                    end
                end
            end
            ST_SPEED: begin
                if (bus.winspeed) begin
                    state_d  = ST_SPEED_DISP;
                    winner_d = bus.win_player;
                end
            end
            ST_SPEED_DISP: begin
                if (bus.speed_exit) begin
                    state_d         = ST_GLOAT;
                    w_credit        = 1'b1;
                    w_credit_player = winner_q;
                end
            end
            ST_GLOAT: begin
                if (bus.slowen && cnt_q == c_gloat_last) begin
                    if (score_a_q == c_win_score || score_b_q == c_win_score) begin
                        state_d        = ST_MATCH_END;
                        match_winner_d = (score_b_q == c_win_score);
                    end else begin
                        state_d = ST_WAIT;
                        rearm_d = 1'b1;
                    end
                end
            end
            ST_MATCH_END: begin
                if (bus.new_match) begin
                    state_d   = ST_WAIT;
                    rearm_d   = 1'b0;
                    score_a_d = '0;
                    score_b_d = '0;
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (w_credit) begin
            if (w_credit_player) begin
                if (score_b_q != c_win_score) score_b_d = score_b_q + 1'b1;
            end else begin
                if (score_a_q != c_win_score) score_a_d = score_a_q + 1'b1;
            end
        end

        if (state_d != state_q) cnt_d = '0;
        else if (bus.slowen)    cnt_d = cnt_q + 1'b1;
        else                    cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RESET;
            cnt_q          <= '0;
            rearm_q        <= 1'b0;
            winner_q       <= 1'b0;
            score_a_q      <= '0;
            score_b_q      <= '0;
            match_winner_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rearm_q        <= rearm_d;
            winner_q       <= winner_d;
            score_a_q      <= score_a_d;
            score_b_q      <= score_b_d;
            match_winner_q <= match_winner_d;
        end
    end

    always_comb begin
        bus.leds_on     = 1'b1;
        bus.clear       = 1'b1;
        bus.led_control = 3'b001;
        bus.fake        = 1'b0;
        bus.speed_round = 1'b0;
        bus.match_over  = 1'b0;
        case (state_q)
            ST_RESET:      bus.led_control = 3'b001;
            ST_WAIT:       bus.led_control = 3'b010;
            ST_DARK: begin
                bus.leds_on     = 1'b0;
                bus.clear       = 1'b0;
                bus.led_control = 3'b000;
            end
            ST_PLAY: begin
                bus.clear       = 1'b0;
                bus.led_control = 3'b011;
            end
            ST_FAKE: begin
                bus.clear       = 1'b0;
                bus.led_control = 3'b100;
                bus.fake        = 1'b1;
            end
            ST_SPEED: begin
                bus.led_control = 3'b010;
                bus.speed_round = 1'b1;
            end
            ST_SPEED_DISP: bus.led_control = 3'b110;
            ST_GLOAT:      bus.led_control = 3'b011;
            ST_MATCH_END: begin
                bus.led_control = 3'b111;
                bus.match_over  = 1'b1;
            end
            default:       bus.led_control = 3'b001;
        endcase
    end

    assign bus.score_a      = score_a_q;
    assign bus.score_b      = score_b_q;
    assign bus.match_winner = match_winner_q;

endmodule

`default_nettype wire
